uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter with an on-chip TX FIFO. Successor to the fixed 8N1 transmitter.

---
 rtl/uart_tx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small TX FIFO in front of it.
// Frame format (data width, parity, stop bits) and bit period are set by parameters.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_CLK,
    input  logic                          i_RESET,
    input  logic                          i_tx_DATA_READY,
    input  logic [DATA_BITS-1:0]          i_tx_DATA,
    output logic                          o_tx_READY,
    output logic                          o_tx_SERIAL,
    output logic                          o_tx_BUSY,
    output logic                          o_tx_DONE,
    output logic                          o_OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_COUNT
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [PW:0]   FULL     = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW:0]          count;
    logic                 overflow;

    state_t               state;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_idx;
    logic                 serial;
    logic                 busy;
    logic                 done;

    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    assign o_tx_READY   = (count != FULL);
    assign push         = i_tx_DATA_READY && o_tx_READY;
    assign pop          = (state == S_IDLE) && (count != '0);
    assign head         = mem[rd_ptr];

    assign o_tx_SERIAL  = serial;
    assign o_tx_BUSY    = busy;
    assign o_tx_DONE    = done;
    assign o_OVERFLOW   = overflow;
    assign o_FIFO_COUNT = count;

    always_ff @(posedge i_CLK) begin
        if (push) begin
            mem[wr_ptr] <= i_tx_DATA;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (i_tx_DATA_READY && !o_tx_READY) begin
                overflow <= 1'b1;
            end
        end
    end

    // Parity is latched at pop time so the shifting register never feeds it.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state   <= S_IDLE;
            shift   <= '0;
            par_bit <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            serial  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    serial  <= 1'b1;
                    clk_cnt <= '0;
                    if (pop) begin
                        shift   <= head;
                        par_bit <= (PARITY == 1) ? ~^head : ^head;
                        serial  <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        serial  <= shift[0];
                        shift   <= shift >> 1;
                        state   <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            if (PARITY != 0) begin
                                serial <= par_bit;
                                state  <= S_PAR;
                            end else begin
                                serial <= 1'b1;
                                state  <= S_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            serial  <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_PAR: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt <= '0;
                        serial  <= 1'b1;
                        state   <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    serial <= 1'b1;
                    if (clk_cnt == STOP_END) begin
                        clk_cnt <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    serial <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8N1 instance plus two 7-bit, 2-stop instances
// (even and odd parity), all at four clocks per bit.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       dr0 = 1'b0;
    logic [7:0] data0 = '0;
    logic       ready0, ser0, busy0, done0, ovf0;
    logic [2:0] cnt0;

    logic       dr1 = 1'b0;
    logic [6:0] data1 = '0;
    logic       ready1, ser1, busy1, done1, ovf1;
    logic [2:0] cnt1;

    logic       dr2 = 1'b0;
    logic [6:0] data2 = '0;
    logic       ready2, ser2, busy2, done2, ovf2;
    logic [2:0] cnt2;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    logic [9:0] rx_sh = '0;
    int         rx_k  = 0;
    bit         rx_act = 1'b0;
    logic [9:0] rx_q[$];
    int         rx_t[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLKS_PER_BIT(4)) dut0 (
        .i_CLK(clk), .i_RESET(rst), .i_tx_DATA_READY(dr0), .i_tx_DATA(data0),
        .o_tx_READY(ready0), .o_tx_SERIAL(ser0), .o_tx_BUSY(busy0), .o_tx_DONE(done0),
        .o_OVERFLOW(ovf0), .o_FIFO_COUNT(cnt0)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut1 (
        .i_CLK(clk), .i_RESET(rst), .i_tx_DATA_READY(dr1), .i_tx_DATA(data1),
        .o_tx_READY(ready1), .o_tx_SERIAL(ser1), .o_tx_BUSY(busy1), .o_tx_DONE(done1),
        .o_OVERFLOW(ovf1), .o_FIFO_COUNT(cnt1)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut2 (
        .i_CLK(clk), .i_RESET(rst), .i_tx_DATA_READY(dr2), .i_tx_DATA(data2),
        .o_tx_READY(ready2), .o_tx_SERIAL(ser2), .o_tx_BUSY(busy2), .o_tx_DONE(done2),
        .o_OVERFLOW(ovf2), .o_FIFO_COUNT(cnt2)
    );

    // Loopback receiver on the 8N1 line: mid-bit sampling, abandons a frame if the
    // transmitter stops being busy before the frame ends.
    always @(negedge clk) begin
        if (!rx_act) begin
            if (ser0 === 1'b0 && busy0 === 1'b1) begin
                rx_act = 1'b1;
                rx_k   = 0;
                rx_t.push_back(cyc);
            end
        end else begin
            rx_k = rx_k + 1;
            if (busy0 !== 1'b1) begin
                rx_act = 1'b0;
            end else begin
                if (rx_k % 4 == 2) rx_sh[rx_k / 4] = ser0;
                if (rx_k == 39) begin
                    rx_q.push_back(rx_sh);
                    rx_act = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got = {ser0, busy0, done0, ovf0, ready0, (cnt0 == 3'd0)};
        n_total++;
        if (got !== 6'b100011) $display("[TB] FAIL reset_dut0: got %b expected 100011", got);
        else n_pass++;
        got = {ser1 & ser2, busy1 | busy2, done1 | done2, ovf1 | ovf2, ready1 & ready2,
               (cnt1 == 3'd0) && (cnt2 == 3'd0)};
        n_total++;
        if (got !== 6'b100011) $display("[TB] FAIL reset_dut12: got %b expected 100011", got);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [9:0] f;
        int dones;
        int bad;
        f = {1'b1, 8'h31, 1'b0};
        dones = 0;
        bad = 0;
        do_reset();
        data0 = 8'h31;
        dr0 = 1'b1;
        @(negedge clk);
        dr0 = 1'b0;
        n_total++;
        if (ser0 !== 1'b1) $display("[TB] FAIL latency_idle: got %b expected 1", ser0);
        else n_pass++;
        for (int k = 0; k < 42; k++) begin
            @(negedge clk);
            if (done0 === 1'b1) dones++;
            if (k < 40 && ser0 !== f[k / 4]) begin
                bad++;
                $display("[TB] FAIL frame_0x31 cycle %0d: got %b expected %b", k, ser0, f[k / 4]);
            end
            if (k == 40) begin
                n_total++;
                if ({done0, busy0, ser0} !== 3'b101)
                    $display("[TB] FAIL done_edge: got done,busy,line=%b expected 101", {done0, busy0, ser0});
                else n_pass++;
            end
        end
        n_total++;
        if (bad != 0) $display("[TB] FAIL frame_0x31: got %0d bad cycles expected 0", bad);
        else n_pass++;
        n_total++;
        if (dones != 1) $display("[TB] FAIL done_pulses: got %0d expected 1", dones);
        else n_pass++;
    endtask

    task automatic test_fill();
        logic [7:0] seen;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            data0 = 8'(i + 1);
            seen[i] = ready0;
            dr0 = ready0;
            @(negedge clk);
        end
        dr0 = 1'b0;
        n_total++;
        if (seen !== 8'h1F) $display("[TB] FAIL ready_pattern: got %b expected 00011111", seen);
        else n_pass++;
        n_total++;
        if ({ready0, cnt0, ovf0} !== {1'b0, 3'd4, 1'b0})
            $display("[TB] FAIL full_state: got ready=%b count=%0d ovf=%b expected 0 4 0", ready0, cnt0, ovf0);
        else n_pass++;
    endtask

    task automatic test_overflow();
        data0 = 8'hAA;
        dr0 = 1'b1;
        @(negedge clk);
        dr0 = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({ovf0, cnt0} !== {1'b1, 3'd4})
            $display("[TB] FAIL overflow: got ovf=%b count=%0d expected 1 4", ovf0, cnt0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        for (int c = 0; c < 400 && rx_q.size() < 5; c++) @(negedge clk);
        n_total++;
        if (rx_q.size() != 5) $display("[TB] FAIL b2b_frames: got %0d expected 5", rx_q.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            n_total++;
            if (rx_q[i] !== {1'b1, exp_b[i], 1'b0})
                $display("[TB] FAIL b2b_word%0d: got %h expected %h", i, rx_q[i], {1'b1, exp_b[i], 1'b0});
            else n_pass++;
            if (i > 0) begin
                n_total++;
                if (rx_t[i] - rx_t[i-1] != 41)
                    $display("[TB] FAIL b2b_spacing%0d: got %0d expected 41", i, rx_t[i] - rx_t[i-1]);
                else n_pass++;
            end
        end
        repeat (20) @(negedge clk);
        n_total++;
        if ({ovf0, cnt0, busy0} !== {1'b1, 3'd0, 1'b0})
            $display("[TB] FAIL sticky_overflow: got ovf=%b count=%0d busy=%b expected 1 0 0", ovf0, cnt0, busy0);
        else n_pass++;
    endtask

    task automatic test_parity();
        logic [10:0] fe;
        logic [10:0] fo;
        int bad_e [11];
        int bad_o [11];
        fe = {2'b11, 1'b1, 7'h4A, 1'b0};
        fo = {2'b11, 1'b0, 7'h4A, 1'b0};
        for (int b = 0; b < 11; b++) begin
            bad_e[b] = 0;
            bad_o[b] = 0;
        end
        do_reset();
        data1 = 7'h4A;
        data2 = 7'h4A;
        dr1 = 1'b1;
        dr2 = 1'b1;
        @(negedge clk);
        dr1 = 1'b0;
        dr2 = 1'b0;
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            if (ser1 !== fe[k / 4]) bad_e[k / 4]++;
            if (ser2 !== fo[k / 4]) bad_o[k / 4]++;
        end
        for (int b = 0; b < 11; b++) begin
            n_total++;
            if (bad_e[b] != 0 || bad_o[b] != 0)
                $display("[TB] FAIL parity_frame bit%0d: got even/odd bad cycles %0d/%0d expected 0/0",
                         b, bad_e[b], bad_o[b]);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if ({done1, done2, busy1, busy2} !== 4'b1100)
            $display("[TB] FAIL parity_done: got %b expected 1100", {done1, done2, busy1, busy2});
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            data0 = words[i];
            dr0 = 1'b1;
            @(negedge clk);
        end
        dr0 = 1'b0;
        repeat (6) @(negedge clk);
        n_total++;
        if ({busy0, cnt0} !== {1'b1, 3'd2})
            $display("[TB] FAIL midframe_state: got busy=%b count=%0d expected 1 2", busy0, cnt0);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({ser0, busy0, done0, cnt0, ready0} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b1})
            $display("[TB] FAIL reset_abort: got line=%b busy=%b done=%b count=%0d ready=%b expected 1 0 0 0 1",
                     ser0, busy0, done0, cnt0, ready0);
        else n_pass++;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ser0 !== 1'b1 || done0 !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0 || rx_q.size() != 0)
            $display("[TB] FAIL post_reset_quiet: got %0d bad cycles %0d frames expected 0 0", bad, rx_q.size());
        else n_pass++;
        data0 = 8'h5A;
        dr0 = 1'b1;
        @(negedge clk);
        dr0 = 1'b0;
        for (int c = 0; c < 100 && rx_q.size() < 1; c++) @(negedge clk);
        n_total++;
        if (rx_q.size() != 1 || rx_q[0] !== {1'b1, 8'h5A, 1'b0})
            $display("[TB] FAIL clean_frame: got %0d frames first %h expected 1 2b4", rx_q.size(),
                     (rx_q.size() > 0) ? rx_q[0] : 10'h0);
        else n_pass++;
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [5] = '{8'h31, 8'hFF, 8'h4A, 8'h01, 8'h2D};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            data0 = bytes[i];
            dr0 = 1'b1;
            @(negedge clk);
        end
        dr0 = 1'b0;
        for (int c = 0; c < 400 && rx_q.size() < 5; c++) @(negedge clk);
        n_total++;
        if (rx_q.size() != 5) $display("[TB] FAIL loopback_count: got %0d expected 5", rx_q.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            n_total++;
            if (rx_q[i][8:1] !== bytes[i] || rx_q[i][0] !== 1'b0 || rx_q[i][9] !== 1'b1)
                $display("[TB] FAIL loopback_byte%0d: got %h expected %h", i, rx_q[i][8:1], bytes[i]);
            else n_pass++;
        end
        n_total++;
        if (ovf0 !== 1'b0) $display("[TB] FAIL loopback_overflow: got %b expected 0", ovf0);
        else n_pass++;
    endtask

    initial begin
        $display("[TB] uart_tx_fifo bench start");
        test_reset();
        test_single_frame();
        test_fill();
        test_overflow();
        test_back_to_back();
        test_parity();
        test_reset_midframe();
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
